muldiv_unit: RTL

Iterative 32-bit multiply/divide unit that sits directly upstream of the HILO register pair in the single-cycle MIPS CPU. It takes register-file operands for MULT/MULTU/DIV/DIVU and computes the 64-bit result over multiple cycles. While it works, it holds `busy` so the control unit can deassert PCWre and stall the PC. It then presents `{hi, lo}` with a one-cycle `done` strobe that the HILO write enable consumes.

---
 rtl/muldiv_if.sv | 25 ++
 rtl/muldiv_unit.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/muldiv_if.sv
// muldiv_if: request/result bundle between the CPU datapath and muldiv_unit.
// master drives the request, slave (the unit) drives status and results.
interface muldiv_if #(
    parameter int XLEN = 32
);
    logic            start;
    logic [1:0]      op;
    logic [XLEN-1:0] inData1;
    logic [XLEN-1:0] inData2;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] hi;
    logic [XLEN-1:0] lo;
    logic            divZero;

    modport master (
        output start, op, inData1, inData2,
        input  busy, done, hi, lo, divZero
    );

    modport slave (
        input  start, op, inData1, inData2,
        output busy, done, hi, lo, divZero
    );
endinterface

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative 32-bit MULT/MULTU/DIV/DIVU feeding HILO.
// Optional MULDIV_EARLY_OUT_EN ends multiplies once the multiplier is spent.
module muldiv_unit #(
    parameter int XLEN = 32
) (
    input logic      CLK,
    input logic      Reset,
    muldiv_if.slave  bus
);
    localparam int CW = $clog2(XLEN);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t            state_q;
    logic [CW-1:0]     cnt_q;
    logic              is_div_q;
    logic              neg_q;
    logic              rneg_q;
    logic [2*XLEN-1:0] acc_q;
    logic [2*XLEN-1:0] mcand_q;
    logic [XLEN-1:0]   mplier_q;
    logic [XLEN-1:0]   rem_q;
    logic              busy_q;
    logic              done_q;
    logic              divz_q;
    logic [XLEN-1:0]   hi_q;
    logic [XLEN-1:0]   lo_q;

    logic              a_neg;
    logic              b_neg;
    logic [XLEN-1:0]   a_mag;
    logic [XLEN-1:0]   b_mag;
    logic [2*XLEN-1:0] acc_n;
    logic [XLEN:0]     shl;
    logic              ge;
    logic [XLEN-1:0]   rem_n;
    logic [XLEN-1:0]   quo_n;
    logic [2*XLEN-1:0] prod_f;
    logic [XLEN-1:0]   quo_f;
    logic [XLEN-1:0]   rem_f;
    logic              mul_exit;
    logic              finish;

    // Operand magnitudes, one iteration step and the signed result fix-up.
    always_comb begin
        a_neg  = bus.op[0] & bus.inData1[XLEN-1];
        b_neg  = bus.op[0] & bus.inData2[XLEN-1];
        a_mag  = a_neg ? -bus.inData1 : bus.inData1;
        b_mag  = b_neg ? -bus.inData2 : bus.inData2;
        acc_n  = mplier_q[0] ? acc_q + mcand_q : acc_q;
        // 33-bit partial remainder; the true difference always fits 32 bits.
        shl    = {rem_q, mplier_q[XLEN-1]};
        ge     = shl >= {1'b0, mcand_q[XLEN-1:0]};
        rem_n  = ge ? shl[XLEN-1:0] - mcand_q[XLEN-1:0] : shl[XLEN-1:0];
        quo_n  = {mplier_q[XLEN-2:0], ge};
        prod_f = neg_q ? -acc_n : acc_n;
        quo_f  = neg_q ? -quo_n : quo_n;
        rem_f  = rneg_q ? -rem_n : rem_n;
`ifdef MULDIV_EARLY_OUT_EN
        mul_exit = (mplier_q[XLEN-1:1] == '0);
`else
        mul_exit = 1'b0;
`endif
        finish = (cnt_q == CW'(XLEN - 1)) | (~is_div_q & mul_exit);
    end

    // Control FSM with registered status and result outputs.
    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            is_div_q <= 1'b0;
            neg_q    <= 1'b0;
            rneg_q   <= 1'b0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            rem_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            divz_q   <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        cnt_q    <= '0;
                        is_div_q <= bus.op[1];
                        neg_q    <= a_neg ^ b_neg;
                        rneg_q   <= a_neg;
                        acc_q    <= '0;
                        rem_q    <= '0;
                        mcand_q  <= {{XLEN{1'b0}}, bus.op[1] ? b_mag : a_mag};
                        mplier_q <= bus.op[1] ? a_mag : b_mag;
                        busy_q   <= 1'b1;
                        if (bus.op[1] && bus.inData2 == '0) begin
                            hi_q    <= bus.inData1;
                            lo_q    <= '1;
                            divz_q  <= 1'b1;
                            done_q  <= 1'b1;
                            state_q <= DONE;
                        end else begin
                            divz_q  <= 1'b0;
                            state_q <= CALC;
                        end
                    end
                end
                CALC: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (is_div_q) begin
                        rem_q    <= rem_n;
                        mplier_q <= quo_n;
                    end else begin
                        acc_q    <= acc_n;
                        mcand_q  <= mcand_q << 1;
                        mplier_q <= mplier_q >> 1;
                    end
                    if (finish) begin
                        if (is_div_q) begin
                            hi_q <= rem_f;
                            lo_q <= quo_f;
                        end else begin
                            hi_q <= prod_f[2*XLEN-1:XLEN];
                            lo_q <= prod_f[XLEN-1:0];
                        end
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.hi      = hi_q;
    assign bus.lo      = lo_q;
    assign bus.divZero = divz_q;
endmodule
